// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Pipeline request/response and data-memory bus signals of the
//                MEM-stage load/store unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_exc;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_byteen;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    // The unit itself: serves pipeline requests, masters the memory bus
    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_exc, stall,
        output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata
    );

    // The environment: pipeline issuing requests plus the memory responder
    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_exc, stall,
        input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM-stage load/store unit with alignment exceptions, store
//                lane steering, load extension and bus timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mem_access_unit_if.slave bus
);
    localparam int                 c_CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_we, w_we_nxt;
    logic [2:0]         r_type, w_type_nxt;
    logic [1:0]         r_lo, w_lo_nxt;
    logic               r_mem_req, w_mem_req_nxt;
    logic               r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nxt;
    logic [3:0]         r_mem_byteen, w_mem_byteen_nxt;
    logic [31:0]        r_mem_wdata, w_mem_wdata_nxt;
    logic [31:0]        r_resp_rdata, w_resp_rdata_nxt;
    logic [1:0]         r_resp_exc, w_resp_exc_nxt;

    logic               w_is_half;
    logic               w_is_byte;
    logic               w_misaligned;
    logic [3:0]         w_st_byteen;
    logic [31:0]        w_st_wdata;
    logic               w_resp_valid;

    // Types 101..111 fall through to word handling
    function automatic logic [31:0] f_load_extend(input logic [2:0]  typ,
                                                  input logic [1:0]  lo,
                                                  input logic [31:0] word);
        logic [15:0] half_sel;
        logic [7:0]  byte_sel;
        logic [31:0] result;
        half_sel = lo[1] ? word[31:16] : word[15:0];
        case (lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        case (typ)
            3'b001:  result = {{16{half_sel[15]}}, half_sel};
            3'b010:  result = {16'h0000, half_sel};
            3'b011:  result = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  result = {24'h000000, byte_sel};
            default: result = word;
        endcase
        return result;
    endfunction

    assign w_is_half    = (bus.req_type == 3'b001) || (bus.req_type == 3'b010);
    assign w_is_byte    = (bus.req_type == 3'b011) || (bus.req_type == 3'b100);
    assign w_misaligned = w_is_half ? bus.req_addr[0]
                        : (!w_is_byte && (bus.req_addr[1:0] != 2'b00));

    always_comb begin
        w_st_byteen = 4'b1111;
        w_st_wdata  = bus.req_wdata;
        if (w_is_byte) begin
            w_st_byteen = 4'b0001 << bus.req_addr[1:0];
            w_st_wdata  = {4{bus.req_wdata[7:0]}};
        end else if (w_is_half) begin
            w_st_byteen = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            w_st_wdata  = {2{bus.req_wdata[15:0]}};
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_we_nxt         = r_we;
        w_type_nxt       = r_type;
        w_lo_nxt         = r_lo;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_byteen_nxt = r_mem_byteen;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_exc_nxt   = r_resp_exc;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_we_nxt   = bus.req_we;
                    w_type_nxt = bus.req_type;
                    w_lo_nxt   = bus.req_addr[1:0];
                    if (w_misaligned) begin
                        w_state_nxt      = S_RESP;
                        w_resp_exc_nxt   = bus.req_we ? 2'b10 : 2'b01;
                        w_resp_rdata_nxt = 32'd0;
                    end else begin
                        w_state_nxt      = S_WAIT;
                        w_cnt_nxt        = '0;
                        w_mem_req_nxt    = 1'b1;
                        w_mem_we_nxt     = bus.req_we;
                        w_mem_addr_nxt   = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        w_mem_byteen_nxt = bus.req_we ? w_st_byteen : 4'b0000;
                        w_mem_wdata_nxt  = bus.req_we ? w_st_wdata : 32'd0;
                    end
                end
            end

            S_WAIT: begin
                if (bus.mem_ack) begin
                    w_state_nxt      = S_RESP;
                    w_resp_exc_nxt   = 2'b00;
                    w_resp_rdata_nxt = r_we ? 32'd0
                                     : f_load_extend(r_type, r_lo, bus.mem_rdata);
                end else if ((MAX_WAIT != 0) && (r_cnt == c_CNT_MAX)) begin
                    w_state_nxt      = S_RESP;
                    w_resp_exc_nxt   = 2'b11;
                    w_resp_rdata_nxt = 32'd0;
                end else if (r_cnt != c_CNT_MAX) begin
                    // Saturates so an unbounded wait cannot wrap the counter
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
                if (w_state_nxt == S_RESP) begin
                    w_mem_req_nxt    = 1'b0;
                    w_mem_we_nxt     = 1'b0;
                    w_mem_addr_nxt   = '0;
                    w_mem_byteen_nxt = 4'b0000;
                    w_mem_wdata_nxt  = 32'd0;
                end
            end

            S_RESP: begin
                w_state_nxt      = S_IDLE;
                w_resp_exc_nxt   = 2'b00;
                w_resp_rdata_nxt = 32'd0;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_type       <= 3'b000;
            r_lo         <= 2'b00;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_byteen <= 4'b0000;
            r_mem_wdata  <= 32'd0;
            r_resp_rdata <= 32'd0;
            r_resp_exc   <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_we         <= w_we_nxt;
            r_type       <= w_type_nxt;
            r_lo         <= w_lo_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_byteen <= w_mem_byteen_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_exc   <= w_resp_exc_nxt;
        end
    end

    assign w_resp_valid   = (r_state == S_RESP);
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_exc   = r_resp_exc;
    assign bus.stall      = bus.req_valid & ~w_resp_valid;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_byteen = r_mem_byteen;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule
`default_nettype wire
